// File: rtl/voice_fetch_scheduler.sv
// Per-sample voice fetch scheduler for the sampler playback path.
// On every sample tick it visits the voice slots in index order. For each
// playing voice it fetches one sample over a single-outstanding Avalon-MM
// read master and adds it to a wide accumulator. At the end of the frame it
// emits one saturated mix sample. The block owns the per-voice playback
// offsets, loop/one-shot termination and the sticky overrun flag.
module voice_fetch_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset_n,
   input  logic                         sample_tick,
   input  logic [NUM_VOICES-1:0]        voice_en,
   input  logic [NUM_VOICES-1:0]        voice_loop,
   input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
   input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
   output logic [ADDR_W-1:0]            mem_address,
   output logic                         mem_read,
   input  logic                         mem_waitrequest,
   input  logic [DATA_W-1:0]            mem_readdata,
   input  logic                         mem_readdatavalid,
   output logic [DATA_W-1:0]            mix_out,
   output logic                         mix_valid,
   output logic [NUM_VOICES-1:0]        voice_playing,
   output logic                         overrun,
   input  logic                         overrun_clr
);

   // Three guard bits: up to eight full-scale samples cannot overflow.
   localparam int ACC_W = DATA_W + 3;
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // Clamp the accumulator into the signed DATA_W output range.
   function automatic logic [DATA_W-1:0] sat_mix(input logic [ACC_W-1:0] a);
      logic [DATA_W-1:0] res;
      if (a[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){a[ACC_W-1]}}) begin
         res = a[DATA_W-1:0];
      end else if (a[ACC_W-1]) begin
         res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         res = {1'b0, {(DATA_W-1){1'b1}}};
      end
      return res;
   endfunction

   logic [2:0]              state_r;
   logic [IDX_W-1:0]        idx_r;
   logic [ACC_W-1:0]        acc_r;
   logic [ADDR_W-1:0]       offset_r [NUM_VOICES];
   logic [NUM_VOICES-1:0]   playing_r;
   logic [NUM_VOICES-1:0]   en_prev_r;
   logic [ADDR_W-1:0]       mem_address_r;
   logic                    mem_read_r;
   logic [DATA_W-1:0]       mix_out_r;
   logic                    mix_valid_r;
   logic                    overrun_r;

   logic [ADDR_W-1:0]       base_s [NUM_VOICES];
   logic [ADDR_W-1:0]       len_s  [NUM_VOICES];
   logic [NUM_VOICES-1:0]   rise_s;
   logic [NUM_VOICES-1:0]   advance_s;
   logic                    rdv_done_s;
   logic                    at_end_s;
   logic [ACC_W-1:0]        sample_ext_s;

   assign mem_address   = mem_address_r;
   assign mem_read      = mem_read_r;
   assign mix_out       = mix_out_r;
   assign mix_valid     = mix_valid_r;
   assign voice_playing = playing_r;
   assign overrun       = overrun_r;

   // Unpack per-voice configuration and derive gate edges and offset steps.
   always_comb begin
      rise_s    = '0;
      advance_s = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         base_s[i]    = voice_base[i*ADDR_W +: ADDR_W];
         len_s[i]     = voice_len[i*ADDR_W +: ADDR_W];
         rise_s[i]    = voice_en[i] & ~en_prev_r[i] & (len_s[i] != '0);
         advance_s[i] = (state_r == ST_WAIT) && mem_readdatavalid && (idx_r == IDX_W'(i));
      end
   end

   // Frame-level helpers for the voice currently being serviced.
   always_comb begin
      rdv_done_s   = (state_r == ST_WAIT) && mem_readdatavalid;
      at_end_s     = (offset_r[idx_r] == (len_s[idx_r] - ADDR_W'(1'b1)));
      sample_ext_s = {{(ACC_W-DATA_W){mem_readdata[DATA_W-1]}}, mem_readdata};
   end

   // Per-voice gating, playback offsets and one-shot termination.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         playing_r <= '0;
         en_prev_r <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            offset_r[i] <= '0;
         end
      end else begin
         en_prev_r <= voice_en;
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (rise_s[i]) begin
               offset_r[i]  <= '0;
               playing_r[i] <= 1'b1;
            end else begin
               if (advance_s[i]) begin
                  if (at_end_s) begin
                     offset_r[i] <= '0;
                     if (!voice_loop[i]) begin
                        playing_r[i] <= 1'b0;
                     end
                  end else begin
                     offset_r[i] <= offset_r[i] + ADDR_W'(1'b1);
                  end
               end
               // A released key stops the voice at once; an outstanding
               // read still completes and is mixed into this frame.
               if (!voice_en[i]) begin
                  playing_r[i] <= 1'b0;
               end
            end
         end
      end
   end

   // Frame sequencer: walk voices, drive the read master, accumulate, emit.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_r       <= ST_IDLE;
         idx_r         <= '0;
         acc_r         <= '0;
         mem_address_r <= '0;
         mem_read_r    <= 1'b0;
         mix_out_r     <= '0;
         mix_valid_r   <= 1'b0;
      end else begin
         mix_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Late readdatavalid from an aborted frame is ignored here.
               if (sample_tick) begin
                  acc_r   <= '0;
                  idx_r   <= '0;
                  state_r <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (playing_r[idx_r]) begin
                  mem_read_r    <= 1'b1;
                  mem_address_r <= base_s[idx_r] + offset_r[idx_r];
                  state_r       <= ST_ISSUE;
               end else if (idx_r == LAST_IDX) begin
                  state_r <= ST_DONE;
               end else begin
                  idx_r <= idx_r + IDX_W'(1'b1);
               end
            end
            ST_ISSUE: begin
               // Address and read stay registered while the slave stalls.
               if (!mem_waitrequest) begin
                  mem_read_r <= 1'b0;
                  state_r    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (rdv_done_s) begin
                  acc_r <= acc_r + sample_ext_s;
                  if (idx_r == LAST_IDX) begin
                     state_r <= ST_DONE;
                  end else begin
                     idx_r   <= idx_r + IDX_W'(1'b1);
                     state_r <= ST_SELECT;
                  end
               end
            end
            ST_DONE: begin
               mix_out_r   <= sat_mix(acc_r);
               mix_valid_r <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               mem_read_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   // Sticky overrun: a tick outside IDLE is dropped and flagged; set beats clear.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         overrun_r <= 1'b0;
      end else if (sample_tick && (state_r != ST_IDLE)) begin
         overrun_r <= 1'b1;
      end else if (overrun_clr) begin
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= overrun_r;
      end
   end

endmodule

// File: tb/tb_voice_fetch_scheduler.sv
// Directed bench for voice_fetch_scheduler: a table of two-voice mix vectors
// plus hand-written sequences for one-shot, loop, stall, overrun and reset.
module tb_voice_fetch_scheduler;

   logic          clk_clk;
   logic          reset_reset_n;
   logic          sample_tick;
   logic [3:0]    voice_en;
   logic [3:0]    voice_loop;
   logic [99:0]   voice_base;
   logic [99:0]   voice_len;
   logic [24:0]   mem_address;
   logic          mem_read;
   logic          mem_waitrequest;
   logic [15:0]   mem_readdata;
   logic          mem_readdatavalid;
   logic [15:0]   mix_out;
   logic          mix_valid;
   logic [3:0]    voice_playing;
   logic          overrun;
   logic          overrun_clr;

   voice_fetch_scheduler dut (
      .clk_clk           (clk_clk),
      .reset_reset_n     (reset_reset_n),
      .sample_tick       (sample_tick),
      .voice_en          (voice_en),
      .voice_loop        (voice_loop),
      .voice_base        (voice_base),
      .voice_len         (voice_len),
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_waitrequest   (mem_waitrequest),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .mix_out           (mix_out),
      .mix_valid         (mix_valid),
      .voice_playing     (voice_playing),
      .overrun           (overrun),
      .overrun_clr       (overrun_clr)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   typedef struct {
      logic [1:0]  en;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [15:0] exp_mix;
      logic [3:0]  exp_play;
   } vec_t;

   vec_t        vecs [10];
   logic [15:0] mem_img [64];
   logic [24:0] addr_log [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          mv_count = 0;
   int          mv_cyc = 0;
   int          tick_cyc = 0;
   int          n_acc = 0;
   int          rd_lat = 1;
   logic [15:0] last_mix = 16'h0;
   logic [15:0] exp_b [4];
   logic [24:0] exp_c [5];
   int          mv0, reads0, lat0, lat1, k;

   // Avalon slave model (one outstanding read, rd_lat cycles) and mix monitor.
   initial begin : bus_model
      logic        acc_pend;
      logic [24:0] acc_addr;
      logic [24:0] rd_addr;
      int          cd;
      acc_pend = 1'b0; acc_addr = '0; rd_addr = '0; cd = 0;
      mem_readdatavalid = 1'b0;
      mem_readdata = 16'h0;
      forever begin
         @(negedge clk_clk);
         if (reset_reset_n && mem_read && !mem_waitrequest) begin
            acc_pend = 1'b1;
            acc_addr = mem_address;
            addr_log.push_back(mem_address);
            n_acc++;
         end
         if (mix_valid) begin
            mv_count++;
            mv_cyc = cyc;
            last_mix = mix_out;
         end
         @(posedge clk_clk);
         cyc++;
         #1;
         mem_readdatavalid = 1'b0;
         if (acc_pend) begin
            acc_pend = 1'b0;
            cd = rd_lat;
            rd_addr = acc_addr;
         end
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               mem_readdatavalid = 1'b1;
               mem_readdata = mem_img[rd_addr[5:0]];
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      tick_cyc = cyc;
      step();
      sample_tick = 1'b0;
   endtask

   task automatic wait_mix(input int n0, input string nm);
      int j = 0;
      while (mv_count == n0 && j < 300) begin
         step();
         j++;
      end
      if (mv_count == n0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout waiting for mix_valid", nm);
      end
   endtask

   task automatic wait_read(input logic lvl, input string nm);
      int j = 0;
      while (mem_read !== lvl && j < 50) begin
         step();
         j++;
      end
      if (mem_read !== lvl) begin
         checks++;
         errors++;
         $display("FAIL %s timeout waiting for mem_read=%0b", nm, lvl);
      end
   endtask

   task automatic set_voice(input int i, input logic [24:0] b, input logic [24:0] l, input logic lp);
      voice_base[i*25 +: 25] = b;
      voice_len[i*25 +: 25]  = l;
      voice_loop[i]          = lp;
   endtask

   initial begin
      vecs[0] = '{en: 2'b11, d0: 16'h7000, d1: 16'h7000, exp_mix: 16'h7FFF, exp_play: 4'b0011};
      vecs[1] = '{en: 2'b11, d0: 16'h9000, d1: 16'h9000, exp_mix: 16'h8000, exp_play: 4'b0011};
      vecs[2] = '{en: 2'b11, d0: 16'd10,   d1: 16'd20,   exp_mix: 16'd30,   exp_play: 4'b0011};
      vecs[3] = '{en: 2'b11, d0: 16'hFFFF, d1: 16'd5,    exp_mix: 16'd4,    exp_play: 4'b0011};
      vecs[4] = '{en: 2'b11, d0: 16'h7FFF, d1: 16'h0001, exp_mix: 16'h7FFF, exp_play: 4'b0011};
      vecs[5] = '{en: 2'b11, d0: 16'h8000, d1: 16'hFFFF, exp_mix: 16'h8000, exp_play: 4'b0011};
      vecs[6] = '{en: 2'b11, d0: 16'h8000, d1: 16'h7FFF, exp_mix: 16'hFFFF, exp_play: 4'b0011};
      vecs[7] = '{en: 2'b01, d0: 16'h1234, d1: 16'h5555, exp_mix: 16'h1234, exp_play: 4'b0001};
      vecs[8] = '{en: 2'b00, d0: 16'h1111, d1: 16'h2222, exp_mix: 16'h0000, exp_play: 4'b0000};
      vecs[9] = '{en: 2'b11, d0: 16'h4000, d1: 16'h3FFF, exp_mix: 16'h7FFF, exp_play: 4'b0011};
      exp_b = '{16'd10, 16'd20, 16'd30, 16'd0};
      exp_c = '{25'h200, 25'h201, 25'h200, 25'h201, 25'h200};
      for (int i = 0; i < 64; i++) mem_img[i] = 16'h0;

      reset_reset_n = 1'b0;
      sample_tick = 1'b0;
      voice_en = 4'b0;
      voice_loop = 4'b0;
      voice_base = '0;
      voice_len = '0;
      mem_waitrequest = 1'b0;
      overrun_clr = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_mix_out", 32'(mix_out), 32'h0);
      chk("rst_mix_valid", 32'(mix_valid), 32'h0);
      chk("rst_mem_read", 32'(mem_read), 32'h0);
      chk("rst_mem_address", 32'(mem_address), 32'h0);
      chk("rst_playing", 32'(voice_playing), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      reset_reset_n = 1'b1;
      repeat (2) step();

      // Table: two looping len-1 voices at fixed addresses, mix and saturation
      set_voice(0, 25'h20, 25'd1, 1'b1);
      set_voice(1, 25'h30, 25'd1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         mem_img[32] = vecs[i].d0;
         mem_img[48] = vecs[i].d1;
         voice_en[1:0] = vecs[i].en;
         mv0 = mv_count;
         tick();
         wait_mix(mv0, $sformatf("vec%0d_wait", i));
         chk($sformatf("vec%0d_mix", i), 32'(last_mix), 32'(vecs[i].exp_mix));
         chk($sformatf("vec%0d_playing", i), 32'(voice_playing), 32'(vecs[i].exp_play));
         repeat (2) step();
      end
      voice_en = 4'b0;
      step();

      // One-shot voice: three samples then silence
      set_voice(0, 25'h100, 25'd3, 1'b0);
      mem_img[0] = 16'd10; mem_img[1] = 16'd20; mem_img[2] = 16'd30;
      addr_log.delete();
      voice_en[0] = 1'b1;
      for (int f = 0; f < 4; f++) begin
         mv0 = mv_count;
         tick();
         wait_mix(mv0, $sformatf("oneshot%0d_wait", f));
         chk($sformatf("oneshot%0d_mix", f), 32'(last_mix), 32'(exp_b[f]));
         chk($sformatf("oneshot%0d_playing", f), 32'(voice_playing[0]), (f < 2) ? 32'h1 : 32'h0);
         repeat (2) step();
      end
      chk("oneshot_reads", 32'(addr_log.size()), 32'd3);
      for (int f = 0; f < 3 && f < addr_log.size(); f++) begin
         chk($sformatf("oneshot_addr%0d", f), 32'(addr_log[f]), 32'h100 + 32'(f));
      end
      voice_en = 4'b0;
      step();

      // Looping voice, len 2, data equals address low bits
      set_voice(0, 25'h200, 25'd2, 1'b1);
      mem_img[0] = 16'd0; mem_img[1] = 16'd1;
      addr_log.delete();
      voice_en[0] = 1'b1;
      for (int f = 0; f < 5; f++) begin
         mv0 = mv_count;
         tick();
         wait_mix(mv0, $sformatf("loop%0d_wait", f));
         chk($sformatf("loop%0d_mix", f), 32'(last_mix), 32'(exp_c[f] & 25'h1));
         repeat (2) step();
      end
      chk("loop_reads", 32'(addr_log.size()), 32'd5);
      for (int f = 0; f < 5 && f < addr_log.size(); f++) begin
         chk($sformatf("loop_addr%0d", f), 32'(addr_log[f]), 32'(exp_c[f]));
      end
      voice_en = 4'b0;
      step();

      // Slave stall: four waitrequest cycles in ISSUE
      set_voice(0, 25'h20, 25'd1, 1'b1);
      mem_img[32] = 16'h0ABC;
      voice_en[0] = 1'b1;
      mv0 = mv_count;
      tick();
      wait_mix(mv0, "stall_base_wait");
      lat0 = mv_cyc - tick_cyc;
      chk("stall_base_mix", 32'(last_mix), 32'h0ABC);
      repeat (2) step();
      reads0 = n_acc;
      mv0 = mv_count;
      mem_waitrequest = 1'b1;
      tick();
      wait_read(1'b1, "stall_issue");
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("stall_read%0d", c), 32'(mem_read), 32'h1);
         chk($sformatf("stall_addr%0d", c), 32'(mem_address), 32'h20);
         step();
      end
      mem_waitrequest = 1'b0;
      wait_mix(mv0, "stall_wait");
      lat1 = mv_cyc - tick_cyc;
      chk("stall_mix", 32'(last_mix), 32'h0ABC);
      chk("stall_delay", 32'(lat1 - lat0), 32'd4);
      chk("stall_one_read", 32'(n_acc - reads0), 32'd1);
      voice_en = 4'b0;
      repeat (2) step();

      // Overrun: busy tick dropped, clear, and set-beats-clear
      set_voice(1, 25'h30, 25'd1, 1'b1);
      mem_img[32] = 16'd7; mem_img[48] = 16'd8;
      voice_en[1:0] = 2'b11;
      mv0 = mv_count;
      tick();
      step();
      tick();
      wait_mix(mv0, "ovr_wait");
      repeat (20) step();
      chk("ovr_one_mix", 32'(mv_count - mv0), 32'd1);
      chk("ovr_mix", 32'(last_mix), 32'd15);
      chk("ovr_set", 32'(overrun), 32'h1);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'h0);
      mv0 = mv_count;
      tick();
      step();
      sample_tick = 1'b1;
      overrun_clr = 1'b1;
      step();
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      chk("ovr_set_wins", 32'(overrun), 32'h1);
      wait_mix(mv0, "ovr2_wait");
      voice_en = 4'b0;
      repeat (2) step();

      // Reset while a read is outstanding, then a clean frame at offset 0
      set_voice(0, 25'h40, 25'd3, 1'b1);
      mem_img[0] = 16'd111; mem_img[1] = 16'd222; mem_img[2] = 16'd333;
      voice_en = 4'b0001;
      mv0 = mv_count;
      tick();
      wait_mix(mv0, "rstw_pre_wait");
      chk("rstw_pre_mix", 32'(last_mix), 32'd111);
      repeat (2) step();
      rd_lat = 4;
      mv0 = mv_count;
      tick();
      wait_read(1'b1, "rstw_issue");
      wait_read(1'b0, "rstw_accept");
      reset_reset_n = 1'b0;
      step();
      chk("rstw_mem_read", 32'(mem_read), 32'h0);
      chk("rstw_mem_address", 32'(mem_address), 32'h0);
      chk("rstw_mix_out", 32'(mix_out), 32'h0);
      chk("rstw_mix_valid", 32'(mix_valid), 32'h0);
      chk("rstw_playing", 32'(voice_playing), 32'h0);
      chk("rstw_overrun", 32'(overrun), 32'h0);
      step();
      reset_reset_n = 1'b1;
      repeat (6) step();
      chk("rstw_no_mix", 32'(mv_count - mv0), 32'd0);
      chk("rstw_idle_read", 32'(mem_read), 32'h0);
      rd_lat = 1;
      mv0 = mv_count;
      tick();
      wait_mix(mv0, "rstw_post_wait");
      chk("rstw_post_mix", 32'(last_mix), 32'd111);
      k = addr_log.size();
      chk("rstw_post_addr", (k > 0) ? 32'(addr_log[k-1]) : 32'hFFFFFFFF, 32'h40);
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
